// File: rtl/uart_tx_fifo_cfg_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_tx_fifo_cfg_if - valid/ready word channel into the UART transmit FIFO.
// Rev 1.0
// ----------------------------------------------------------------------------
interface uart_tx_fifo_cfg_if #(
  parameter int DATA_W = 8
);
  logic              tx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              tx_ready;

  modport master (output tx_valid, output tx_data, input tx_ready);
  modport slave  (input tx_valid, input tx_data, output tx_ready);
endinterface
`default_nettype wire

// File: rtl/uart_tx_fifo_cfg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_tx_fifo_cfg - UART transmitter with configurable width/parity/stop bits
// fed from a transmit FIFO; frames stream back-to-back.   Rev 1.0
// ----------------------------------------------------------------------------
module uart_tx_fifo_cfg #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int DATA_W     = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  uart_tx_fifo_cfg_if.slave           s_if,
  output logic                        tx_busy_o,
  output logic                        tx_done_o,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count_o,
  output logic                        uart_tx_d_o
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD;
  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam int CW       = AW + 1;
  localparam int BCW      = $clog2(BAUD_DIV);

  generate
    if (DATA_W < 5 || DATA_W > 8 || PARITY < 0 || PARITY > 2 ||
        STOP_BITS < 1 || STOP_BITS > 2 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || BAUD_DIV < 4) begin : g_bad_params
      $error("uart_tx_fifo_cfg: illegal parameter combination");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_PAR   = 3'd3,
    S_STOP  = 3'd4
  } state_t;

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q,  count_d;
  logic              rdy_en_q;

  state_t            state_q,  state_d;
  logic [DATA_W-1:0] shift_q,  shift_d;
  logic              par_q,    par_d;
  logic [BCW-1:0]    baud_q,   baud_d;
  logic [2:0]        bit_q,    bit_d;
  logic              line_q,   line_d;
  logic              done_q,   done_d;
  logic              busy_q,   busy_d;

  logic              push, pop, load, baud_last;
  logic [DATA_W-1:0] head;

  // Readiness comes only from registered state; a same-edge pop cannot admit a word.
  assign s_if.tx_ready = rdy_en_q && (count_q != CW'(FIFO_DEPTH));
  assign push          = s_if.tx_valid && s_if.tx_ready;
  assign head          = mem_q[rd_ptr_q];
  assign baud_last     = (baud_q == BCW'(BAUD_DIV - 1));

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    par_d   = par_q;
    baud_d  = baud_last ? '0 : baud_q + 1'b1;
    bit_d   = bit_q;
    done_d  = 1'b0;
    load    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        baud_d = '0;
        load   = (count_q != '0);
      end
      S_START: if (baud_last) begin
        state_d = S_DATA;
        bit_d   = '0;
      end
      S_DATA: if (baud_last) begin
        shift_d = shift_q >> 1;
        if (bit_q == 3'(DATA_W - 1)) begin
          bit_d   = '0;
          state_d = (PARITY != 0) ? S_PAR : S_STOP;
        end else begin
          bit_d = bit_q + 1'b1;
        end
      end
      S_PAR: if (baud_last) begin
        state_d = S_STOP;
        bit_d   = '0;
      end
      S_STOP: if (baud_last) begin
        if (bit_q == 3'(STOP_BITS - 1)) begin
          done_d  = 1'b1;
          bit_d   = '0;
          state_d = S_IDLE;
          load    = (count_q != '0);
        end else begin
          bit_d = bit_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Loading from IDLE or from the final stop tick gives the zero-gap restart.
    if (load) begin
      state_d = S_START;
      shift_d = head;
      par_d   = (PARITY == 2) ? ^head : ~^head;
    end
    pop = load;

    count_d = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;

    unique case (state_q)
      S_START: line_d = 1'b0;
      S_DATA:  line_d = shift_q[0];
      S_PAR:   line_d = par_q;
      default: line_d = 1'b1;
    endcase
    busy_d = (state_q != S_IDLE) || (count_q != '0);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= s_if.tx_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rdy_en_q <= 1'b0;
      state_q  <= S_IDLE;
      shift_q  <= '0;
      par_q    <= 1'b0;
      baud_q   <= '0;
      bit_q    <= '0;
      line_q   <= 1'b1;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q  <= count_d;
      rdy_en_q <= 1'b1;
      state_q  <= state_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      line_q   <= line_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign tx_busy_o    = busy_q;
  assign tx_done_o    = done_q;
  assign fifo_count_o = count_q;
  assign uart_tx_d_o  = line_q;

endmodule
`default_nettype wire

// File: doc/uart_tx_fifo_cfg.md
Name: uart_tx_fifo_cfg

Overview:
Parametrised UART transmitter. It replaces the fixed 8N1 transmitter and adds configurable data width, parity, stop bits and a transmit FIFO with a valid/ready input handshake. It sits between byte producers (e.g. SPI flash readback and debug dump logic) and the board TX pin. It streams back-to-back frames with no idle gap while the FIFO holds data.

Parameters:
CLK_FREQ, 50_000_000, system clock frequency in Hz.
BAUD, 115200, line rate; BAUD_DIV = CLK_FREQ/BAUD (integer floor), must be >= 4.
DATA_W, 8, data bits per frame; legal range 5..8.
PARITY, 0, 0 = none, 1 = odd, 2 = even.
STOP_BITS, 1, 1 or 2.
FIFO_DEPTH, 16, transmit FIFO entries; power of 2, >= 2.

Ports:
clk  in  1  system clock.
rst_n  in  1  reset, synchronous, active-low.
tx_valid  in  1  producer has a word on tx_data.
tx_data  in  DATA_W  word to send; bit 0 is sent first.
tx_ready  out  1  FIFO can accept; high when the FIFO is not full.
tx_busy  out  1  high while a frame is on the line or the FIFO is non-empty.
tx_done  out  1  one-cycle pulse at the end of each frame's last stop bit.
fifo_count  out  $clog2(FIFO_DEPTH)+1  number of entries currently in the FIFO.
uart_tx_d  out  1  serial line, registered, idle high.

Behaviour:
- Reset (rst_n=0 at a clk edge): uart_tx_d=1, tx_ready=0 during reset and 1 on the first cycle after it, tx_busy=0, tx_done=0, fifo_count=0. FIFO pointers, shift register, baud counter and bit counter are cleared. Reset mid-frame aborts the frame: the line is high on the next edge and queued data is discarded.
- Accept: a write happens on any edge where tx_valid && tx_ready. tx_ready = (fifo_count != FIFO_DEPTH) and is computed from registered state only. A pop on the same edge does not raise tx_ready that cycle.
- Simultaneous push and pop: fifo_count is unchanged and both pointers advance.
- Pointer wrap: pointers wrap modulo FIFO_DEPTH. Full/empty status is taken from fifo_count.
- FSM states: IDLE, START, DATA, PAR, STOP.
  - IDLE: if the FIFO is non-empty, pop the head into the shift register and go to START.
  - START: drive 0 for BAUD_DIV cycles.
  - DATA: drive shift[0], shift right, DATA_W bits of BAUD_DIV cycles each.
  - PAR: only entered if PARITY != 0. Parity bit = ^data for even, ~^data for odd, so the total count of ones in data+parity is even or odd respectively. Lasts BAUD_DIV cycles.
  - STOP: drive 1 for STOP_BITS*BAUD_DIV cycles.
  - End of STOP: pulse tx_done. If the FIFO is non-empty, pop and go straight to START on the same edge (zero idle gap); otherwise go to IDLE.
- Baud counter: runs 0..BAUD_DIV-1 in every non-IDLE state and resets to 0 on each bit boundary and in IDLE. Each bit is exactly BAUD_DIV cycles.
- Latency:
  - Accept at edge N into an empty FIFO with the FSM in IDLE gives a pop at edge N+1 and uart_tx_d=0 from edge N+2.
  - Frame length = (1 + DATA_W + (PARITY!=0) + STOP_BITS) * BAUD_DIV cycles.
- tx_busy: equals (state != IDLE) || (fifo_count != 0), registered. It is set on the edge after the first accept and cleared the cycle after tx_done if nothing is queued.
- tx_data bits above DATA_W do not exist. Only DATA_W bits are stored, so the FIFO width is DATA_W.
- An illegal parameter combination (DATA_W outside 5..8, PARITY > 2, STOP_BITS outside 1..2, FIFO_DEPTH not a power of 2) is an elaboration-time error.

Test Plan:
- 8N1, CLK_FREQ=1_000_000, BAUD=100_000 (BAUD_DIV=10). Single push of 0xA5 -> uart_tx_d = 0,1,0,1,0,0,1,0,1,1, each bit held 10 cycles. tx_done pulses once, 100 cycles after the start bit begins. tx_busy returns to 0.
- PARITY=2 with 0x07 -> parity bit 1. PARITY=1 with 0x07 -> parity bit 0. PARITY=2 with 0x00 -> parity bit 0. Frame is 110 cycles long.
- STOP_BITS=2, push 0x55 then 0xAA on consecutive cycles -> stop phase lasts 20 cycles. The second start bit begins on the cycle immediately after the first frame's stop phase. Two tx_done pulses 110 cycles apart.
- FIFO_DEPTH=16, tx_valid held high with incrementing data -> 17 accepts before tx_ready drops (16 in the FIFO plus 1 in the shifter). fifo_count=16. tx_ready re-asserts one cycle after the next pop. All 17 words appear on the line in order.
- Reset asserted for 1 cycle in the middle of the DATA phase with 3 words queued -> uart_tx_d=1 and fifo_count=0 on the next edge. No further tx_done pulses. A new push afterwards transmits cleanly.
- DATA_W=5, PARITY=0, push 0x1F -> line shows 0,1,1,1,1,1,1. Frame is 70 cycles long.
